// File: rtl/switch_word_capture_pkg.sv
// Shared types and sizing helpers for switch_word_capture and its debouncer.
package switch_word_capture_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } cap_state_t;

    function automatic int nchunk(input int word_w, input int sw_w);
        return (word_w + sw_w - 1) / sw_w;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; pulses one cycle when the
// debounced level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYC <= 1) ? 1 : $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    // The debounced level only moves after DEBOUNCE_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 != r_stable) begin
                if (r_cnt == CNT_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                    r_pulse  <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/switch_word_capture.sv
// Assembles a WORD_W-bit word from SW_W-bit switch chunks, low chunk first.
// Optional SIGNMAG_EN build converts a sign-magnitude word to two's complement.
module switch_word_capture
    import switch_word_capture_pkg::*;
#(
    parameter int SW_W         = 16,
    parameter int WORD_W       = 32,
    parameter int DEBOUNCE_CYC = 20
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [SW_W-1:0]                       sw_in,
    input  logic                                  btn_in,
    input  logic                                  cancel,
    input  logic                                  sign_mag,
    input  logic                                  out_ready,
    output logic [WORD_W-1:0]                     out_data,
    output logic                                  out_valid,
    output logic                                  start,
    output logic [idx_w(nchunk(WORD_W, SW_W))-1:0] chunk_idx,
    output logic                                  overrun,
    output cap_state_t                            dbg_state
);

    localparam int NCHUNK = nchunk(WORD_W, SW_W);
    localparam int IDX_W  = idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    logic [SW_W-1:0]   r_sw_s1, r_sw_s2;
    logic              r_cancel_s1, r_cancel_s2;
    logic              w_press;
    logic [WORD_W-1:0] w_word_next;
    logic [WORD_W-1:0] w_out;

    cap_state_t        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;
    logic              r_start;
    logic              r_overrun;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_in),
        .pulse (w_press)
    );

    // Same two stages as the button so the switches line up with the press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_s1     <= '0;
            r_sw_s2     <= '0;
            r_cancel_s1 <= 1'b0;
            r_cancel_s2 <= 1'b0;
        end else begin
            r_sw_s1     <= sw_in;
            r_sw_s2     <= r_sw_s1;
            r_cancel_s1 <= cancel;
            r_cancel_s2 <= r_cancel_s1;
        end
    end

    always_comb begin
        w_word_next = r_word;
        for (int b = 0; b < WORD_W; b++) begin
            if (b / SW_W == int'(r_idx)) w_word_next[b] = r_sw_s2[b % SW_W];
        end
    end

`ifdef SIGNMAG_EN
    logic r_sm_s1, r_sm_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sm_s1 <= 1'b0;
            r_sm_s2 <= 1'b0;
        end else begin
            r_sm_s1 <= sign_mag;
            r_sm_s2 <= r_sm_s1;
        end
    end

    // Negating the magnitude maps negative zero onto zero for free.
    assign w_out = (r_sm_s2 && w_word_next[WORD_W-1])
                 ? ({WORD_W{1'b0}} - {1'b0, w_word_next[WORD_W-2:0]})
                 : w_word_next;
`else
    logic w_unused_sign_mag;
    assign w_unused_sign_mag = sign_mag;
    assign w_out = w_word_next;
`endif

    // Handshake: out_valid stays high with out_data stable until a cycle with out_ready high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= COLLECT;
            r_idx     <= '0;
            r_word    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_start   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (r_cancel_s2) begin
                        r_idx  <= '0;
                        r_word <= '0;
                    end else if (w_press) begin
                        if (r_idx == LAST_IDX) begin
                            r_data  <= w_out;
                            r_valid <= 1'b1;
                            r_start <= 1'b1;
                            r_idx   <= '0;
                            r_word  <= '0;
                            r_state <= HOLD;
                        end else begin
                            r_word <= w_word_next;
                            r_idx  <= r_idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (r_valid && out_ready) begin
                        r_valid   <= 1'b0;
                        r_overrun <= 1'b0;
                        r_state   <= COLLECT;
                    end else if (w_press) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign start     = r_start;
    assign chunk_idx = r_idx;
    assign overrun   = r_overrun;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_switch_word_capture.sv
// Self-checking bench: a 16/32 instance and a 12/32 instance against a chunk-list model.
module tb_switch_word_capture;
    import switch_word_capture_pkg::*;

    localparam int D   = 4;
    localparam int LAT = 2 + D + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] sw_a = '0;
    logic        btn_a = 1'b0, cancel_a = 1'b0, sm_a = 1'b0, rdy_a = 1'b0;
    logic [31:0] data_a;
    logic        valid_a, start_a, ovr_a;
    logic [0:0]  idx_a;
    cap_state_t  st_a;

    logic [11:0] sw_b = '0;
    logic        btn_b = 1'b0, cancel_b = 1'b0, sm_b = 1'b0, rdy_b = 1'b0;
    logic [31:0] data_b;
    logic        valid_b, start_b, ovr_b;
    logic [1:0]  idx_b;
    cap_state_t  st_b;

    switch_word_capture #(.SW_W(16), .WORD_W(32), .DEBOUNCE_CYC(D)) dut_a (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_a), .btn_in(btn_a), .cancel(cancel_a),
        .sign_mag(sm_a), .out_ready(rdy_a), .out_data(data_a), .out_valid(valid_a),
        .start(start_a), .chunk_idx(idx_a), .overrun(ovr_a), .dbg_state(st_a)
    );

    switch_word_capture #(.SW_W(12), .WORD_W(32), .DEBOUNCE_CYC(D)) dut_b (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_b), .btn_in(btn_b), .cancel(cancel_b),
        .sign_mag(sm_b), .out_ready(rdy_b), .out_data(data_b), .out_valid(valid_b),
        .start(start_b), .chunk_idx(idx_b), .overrun(ovr_b), .dbg_state(st_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Start-pulse monitor
    int   starts_a = 0, starts_b = 0, dbl_start = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;
    always @(negedge clk) begin
        if (start_a && prev_a) dbl_start++;
        if (start_b && prev_b) dbl_start++;
        if (start_a) starts_a++;
        if (start_b) starts_b++;
        prev_a = start_a;
        prev_b = start_b;
    end

    // Reference model: list of accepted chunks per instance
    int          m_cnt[2];
    logic [31:0] m_chunks[2][3];
    bit          m_pend[2];
    bit          m_ovr[2];
    logic [31:0] m_word[2];
    int          m_starts[2];

    function automatic logic [31:0] sm_convert(input logic [31:0] w, input logic sm);
        logic [31:0] r;
        r = w;
`ifdef SIGNMAG_EN
        if (sm && w[31]) r = 32'd0 - (w & 32'h7FFF_FFFF);
`else
        if (sm) r = w;
`endif
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_pend[d] = 0; m_ovr[d] = 0; m_word[d] = '0;
        end
    endtask

    task automatic model_press(input int d, input logic [31:0] val);
        int nch, sww;
        logic [63:0] acc;
        nch = (d != 0) ? 3 : 2;
        sww = (d != 0) ? 12 : 16;
        if (m_pend[d]) begin
            m_ovr[d] = 1;
            return;
        end
        m_chunks[d][m_cnt[d]] = val & ((32'd1 << sww) - 1);
        m_cnt[d]++;
        if (m_cnt[d] == nch) begin
            acc = '0;
            for (int k = 0; k < nch; k++) acc = acc + (64'(m_chunks[d][k]) << (k * sww));
            m_word[d] = sm_convert(acc[31:0], (d == 0) ? sm_a : 1'b0);
            m_pend[d] = 1;
            m_cnt[d] = 0;
            m_starts[d]++;
        end
    endtask

    task automatic model_consume(input int d);
        if (m_pend[d]) begin
            m_pend[d] = 0;
            m_ovr[d] = 0;
        end
    endtask

    task automatic press(input int d, input logic [31:0] val);
        @(negedge clk);
        if (d == 0) begin sw_a = val[15:0]; btn_a = 1'b1; end
        else begin sw_b = val[11:0]; btn_b = 1'b1; end
        repeat (10) @(negedge clk);
        btn_a = 1'b0;
        btn_b = 1'b0;
        repeat (10) @(negedge clk);
        model_press(d, val);
    endtask

    task automatic consume(input int d);
        @(negedge clk);
        if (d == 0) rdy_a = 1'b1; else rdy_b = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        model_consume(d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({st_a, valid_a, start_a, ovr_a, idx_a, data_a} !== 37'h0) begin
            n_err++;
            $display("FAIL reset_a: got st=%0d v=%0b s=%0b o=%0b i=%0d d=%h, want all 0",
                     st_a, valid_a, start_a, ovr_a, idx_a, data_a);
        end
        n_vec++;
        if ({st_b, valid_b, start_b, ovr_b, idx_b, data_b} !== 38'h0) begin
            n_err++;
            $display("FAIL reset_b: got st=%0d v=%0b s=%0b o=%0b i=%0d d=%h, want all 0",
                     st_b, valid_b, start_b, ovr_b, idx_b, data_b);
        end
        model_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] v0, v1;
        press(0, 32'h5678);
        n_vec++;
        if ({valid_a, idx_a} !== {1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL basic_first_chunk: got v=%0b i=%0d, want v=0 i=1", valid_a, idx_a);
        end
        @(negedge clk);
        sw_a = 16'h1234;
        btn_a = 1'b1;
        lat = 0;
        while (!valid_a && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat != LAT) begin
            n_err++;
            $display("FAIL basic_latency: got %0d cycles, want %0d", lat, LAT);
        end
        n_vec++;
        if (start_a !== 1'b1) begin
            n_err++;
            $display("FAIL basic_start_rise: got %0b, want 1", start_a);
        end
        @(negedge clk);
        n_vec++;
        if (start_a !== 1'b0) begin
            n_err++;
            $display("FAIL basic_start_width: got %0b, want 0", start_a);
        end
        repeat (8) @(negedge clk);
        btn_a = 1'b0;
        repeat (10) @(negedge clk);
        model_press(0, 32'h1234);
        n_vec++;
        if ({st_a, valid_a, ovr_a, idx_a, data_a} !== {m_pend[0], m_pend[0], m_ovr[0], 1'(m_cnt[0]), m_word[0]}
            || data_a !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL basic_word: got st=%0d v=%0b o=%0b i=%0d d=%h, want v=1 o=0 i=0 d=12345678",
                     st_a, valid_a, ovr_a, idx_a, data_a);
        end
        consume(0);

        press(0, $urandom);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({valid_a, start_a, ovr_a, idx_a, data_a} !== 36'h0) begin
            n_err++;
            $display("FAIL basic_mid_reset: got v=%0b s=%0b o=%0b i=%0d d=%h, want all 0",
                     valid_a, start_a, ovr_a, idx_a, data_a);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        v0 = $urandom_range(0, 16'hFFFF);
        v1 = $urandom_range(0, 16'hFFFF);
        press(0, v0);
        press(0, v1);
        n_vec++;
        if ({valid_a, idx_a, data_a} !== {m_pend[0], 1'(m_cnt[0]), m_word[0]}) begin
            n_err++;
            $display("FAIL basic_after_reset: got v=%0b i=%0d d=%h, want v=%0b i=%0d d=%h",
                     valid_a, idx_a, data_a, m_pend[0], m_cnt[0], m_word[0]);
        end
        consume(0);
    endtask

    task automatic test_bounce();
        @(negedge clk);
        sw_a = 16'($urandom);
        for (int g = 0; g < 5; g++) begin
            btn_a = 1'b1;
            repeat (3) @(negedge clk);
            btn_a = 1'b0;
            repeat (2) @(negedge clk);
        end
        n_vec++;
        if (idx_a !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_glitch: got idx=%0d, want 0", idx_a);
        end
        btn_a = 1'b1;
        repeat (10) @(negedge clk);
        btn_a = 1'b0;
        repeat (10) @(negedge clk);
        model_press(0, 32'(sw_a));
        n_vec++;
        if ({valid_a, idx_a} !== {1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL bounce_one_press: got v=%0b idx=%0d, want v=0 idx=1", valid_a, idx_a);
        end
        press(0, $urandom);
        n_vec++;
        if ({valid_a, data_a} !== {1'b1, m_word[0]}) begin
            n_err++;
            $display("FAIL bounce_word: got v=%0b d=%h, want v=1 d=%h", valid_a, data_a, m_word[0]);
        end
        consume(0);
    endtask

    task automatic test_overrun();
        logic [31:0] held;
        press(0, $urandom);
        press(0, $urandom);
        held = m_word[0];
        press(0, $urandom);
        n_vec++;
        if ({st_a, valid_a, ovr_a, idx_a, data_a} !== {1'b1, 1'b1, 1'b1, 1'b0, held}) begin
            n_err++;
            $display("FAIL overrun_set: got st=%0d v=%0b o=%0b i=%0d d=%h, want st=1 v=1 o=1 i=0 d=%h",
                     st_a, valid_a, ovr_a, idx_a, data_a, held);
        end
        consume(0);
        n_vec++;
        if ({st_a, valid_a, ovr_a} !== 3'b000) begin
            n_err++;
            $display("FAIL overrun_clear: got st=%0d v=%0b o=%0b, want 0 0 0", st_a, valid_a, ovr_a);
        end
        press(0, $urandom);
        press(0, $urandom);
        @(negedge clk);
        sw_a = 16'($urandom);
        btn_a = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        model_consume(0);
        n_vec++;
        if ({valid_a, ovr_a, idx_a} !== 3'b000) begin
            n_err++;
            $display("FAIL overrun_coincident: got v=%0b o=%0b i=%0d, want 0 0 0", valid_a, ovr_a, idx_a);
        end
        repeat (4) @(negedge clk);
        btn_a = 1'b0;
        repeat (10) @(negedge clk);
        n_vec++;
        if ({valid_a, ovr_a, idx_a} !== 3'b000) begin
            n_err++;
            $display("FAIL overrun_dropped: got v=%0b o=%0b i=%0d, want 0 0 0", valid_a, ovr_a, idx_a);
        end
    endtask

    task automatic test_cancel();
        press(0, 32'hAAAA);
        @(negedge clk);
        cancel_a = 1'b1;
        repeat (3) @(negedge clk);
        cancel_a = 1'b0;
        repeat (3) @(negedge clk);
        m_cnt[0] = 0;
        n_vec++;
        if (idx_a !== 1'b0) begin
            n_err++;
            $display("FAIL cancel_idx: got %0d, want 0", idx_a);
        end
        press(0, 32'h0001);
        press(0, 32'h0002);
        n_vec++;
        if ({valid_a, data_a} !== {1'b1, 32'h0002_0001} || data_a !== m_word[0]) begin
            n_err++;
            $display("FAIL cancel_word: got v=%0b d=%h, want v=1 d=00020001", valid_a, data_a);
        end
        @(negedge clk);
        cancel_a = 1'b1;
        repeat (3) @(negedge clk);
        cancel_a = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({valid_a, data_a} !== {1'b1, m_word[0]}) begin
            n_err++;
            $display("FAIL cancel_in_hold: got v=%0b d=%h, want v=1 d=%h", valid_a, data_a, m_word[0]);
        end
        consume(0);
    endtask

    task automatic test_narrow();
        logic [31:0] v;
        press(1, 32'hABC);
        press(1, 32'hDEF);
        n_vec++;
        if ({valid_b, idx_b} !== {1'b0, 2'd2}) begin
            n_err++;
            $display("FAIL narrow_idx: got v=%0b i=%0d, want v=0 i=2", valid_b, idx_b);
        end
        press(1, 32'hF12);
        n_vec++;
        if ({valid_b, idx_b, data_b} !== {1'b1, 2'd0, 32'h12DE_FABC} || data_b !== m_word[1]) begin
            n_err++;
            $display("FAIL narrow_word: got v=%0b i=%0d d=%h, want v=1 i=0 d=12defabc", valid_b, idx_b, data_b);
        end
        consume(1);
        for (int w = 0; w < 2; w++) begin
            for (int c = 0; c < 3; c++) begin
                v = $urandom;
                press(1, v);
            end
            n_vec++;
            if ({valid_b, data_b} !== {m_pend[1], m_word[1]}) begin
                n_err++;
                $display("FAIL narrow_random: got v=%0b d=%h, want v=%0b d=%h", valid_b, data_b, m_pend[1], m_word[1]);
            end
            consume(1);
        end
    endtask

    task automatic test_signmag();
        logic [31:0] want;
        sm_a = 1'b1;
        press(0, 32'h0005);
        press(0, 32'h8000);
`ifdef SIGNMAG_EN
        want = 32'hFFFF_FFFB;
`else
        want = 32'h8000_0005;
`endif
        n_vec++;
        if (data_a !== want || data_a !== m_word[0]) begin
            n_err++;
            $display("FAIL signmag_neg5: got %h, want %h", data_a, want);
        end
        consume(0);
        press(0, 32'h0000);
        press(0, 32'h8000);
        n_vec++;
        if (data_a !== m_word[0]) begin
            n_err++;
            $display("FAIL signmag_negzero: got %h, want %h", data_a, m_word[0]);
        end
        consume(0);
        sm_a = 1'b0;
        press(0, 32'h0005);
        press(0, 32'h8000);
        n_vec++;
        if (data_a !== 32'h8000_0005) begin
            n_err++;
            $display("FAIL signmag_off: got %h, want 80000005", data_a);
        end
        consume(0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            if (m_pend[0] && $urandom_range(0, 2) != 0) consume(0);
            else press(0, $urandom);
            n_vec++;
            if ({st_a, valid_a, ovr_a, idx_a, data_a} !== {m_pend[0], m_pend[0], m_ovr[0], 1'(m_cnt[0]), m_word[0]}) begin
                n_err++;
                $display("FAIL random_%0d: got st=%0d v=%0b o=%0b i=%0d d=%h, want v=%0b o=%0b i=%0d d=%h",
                         i, st_a, valid_a, ovr_a, idx_a, data_a, m_pend[0], m_ovr[0], m_cnt[0], m_word[0]);
            end
        end
        consume(0);
    endtask

    initial begin
        m_starts[0] = 0;
        m_starts[1] = 0;
        model_reset();
        test_reset();
        test_basic();
        test_bounce();
        test_overrun();
        test_cancel();
        test_narrow();
        test_signmag();
        test_random();
        repeat (3) @(negedge clk);
        n_vec++;
        if (starts_a != m_starts[0] || starts_b != m_starts[1]) begin
            n_err++;
            $display("FAIL start_count: got %0d/%0d, want %0d/%0d", starts_a, starts_b, m_starts[0], m_starts[1]);
        end
        n_vec++;
        if (dbl_start != 0) begin
            n_err++;
            $display("FAIL start_back_to_back: got %0d double pulses, want 0", dbl_start);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
